// File: rtl/ad9361_multi_sync.sv
// Multi-chip AD9361 ENABLE/TXNRX sync controller: applies per-chip updates on a
// TDD sync event, either generated locally (master) or taken from tdd_sync_i (slave).
module ad9361_multi_sync #(
    parameter int NUM_CHIPS        = 2,
    parameter int SYNC_PULSE_WIDTH = 4,
    parameter int ARM_TIMEOUT      = 1024
) (
    input  logic                 axi_aclk,
    input  logic                 axi_areset,
    input  logic                 mode_master,
    input  logic                 sync_arm,
    input  logic [NUM_CHIPS-1:0] up_enable,
    input  logic [NUM_CHIPS-1:0] up_txnrx,
    output logic [NUM_CHIPS-1:0] enable,
    output logic [NUM_CHIPS-1:0] txnrx,
    input  logic                 tdd_sync_i,
    output logic                 tdd_sync_o,
    output logic                 tdd_sync_t,
    output logic                 sync_busy,
    output logic                 sync_done,
    output logic                 sync_timeout,
    output logic [15:0]          sync_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PULSE = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(ARM_TIMEOUT - 1);
    localparam logic [15:0] PULSE_LAST   = 16'(SYNC_PULSE_WIDTH - 1);

    state_t                state_reg, state_next;
    logic                  mode_q_reg, mode_q_next;
    logic [15:0]           cnt_reg, cnt_next;
    logic [NUM_CHIPS-1:0]  enable_reg, enable_next;
    logic [NUM_CHIPS-1:0]  txnrx_reg, txnrx_next;
    logic                  sync_o_reg, sync_o_next;
    logic                  sync_t_reg;
    logic                  done_reg, done_next;
    logic                  timeout_reg, timeout_next;
    logic [15:0]           sync_count_reg, sync_count_next;
    logic [2:0]            sync_q_reg;
    logic                  sync_edge;
    logic                  load_event;

    // bits 0/1 resynchronise the pin, bit 2 is the previous value for edge detect
    assign sync_edge = sync_q_reg[1] & ~sync_q_reg[2];

    always_comb begin
        state_next      = state_reg;
        mode_q_next     = mode_q_reg;
        cnt_next        = cnt_reg;
        sync_o_next     = 1'b0;
        done_next       = 1'b0;
        timeout_next    = timeout_reg;
        sync_count_next = sync_count_reg;
        load_event      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = 16'd0;
                if (sync_arm) begin
                    state_next   = ST_ARMED;
                    mode_q_next  = mode_master;
                    timeout_next = 1'b0;
                end
            end
            ST_ARMED: begin
                if (mode_q_reg) begin
                    state_next  = ST_PULSE;
                    load_event  = 1'b1;
                    sync_o_next = 1'b1;
                    cnt_next    = 16'd0;
                end else if (sync_edge) begin
                    state_next      = ST_IDLE;
                    load_event      = 1'b1;
                    done_next       = 1'b1;
                    sync_count_next = sync_count_reg + 16'd1;
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_PULSE: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next      = ST_IDLE;
                    done_next       = 1'b1;
                    sync_count_next = sync_count_reg + 16'd1;
                end else begin
                    sync_o_next = 1'b1;
                    cnt_next    = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_CHIPS; gi++) begin : g_chip
            assign enable_next[gi] = load_event ? up_enable[gi] : enable_reg[gi];
            assign txnrx_next[gi]  = load_event ? up_txnrx[gi]  : txnrx_reg[gi];
        end
    endgenerate

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_reg      <= ST_IDLE;
            mode_q_reg     <= 1'b0;
            cnt_reg        <= 16'd0;
            enable_reg     <= '0;
            txnrx_reg      <= '0;
            sync_o_reg     <= 1'b0;
            sync_t_reg     <= 1'b1;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            sync_count_reg <= 16'd0;
            sync_q_reg     <= 3'b000;
        end else begin
            state_reg      <= state_next;
            mode_q_reg     <= mode_q_next;
            cnt_reg        <= cnt_next;
            enable_reg     <= enable_next;
            txnrx_reg      <= txnrx_next;
            sync_o_reg     <= sync_o_next;
            sync_t_reg     <= ~mode_master;
            done_reg       <= done_next;
            timeout_reg    <= timeout_next;
            sync_count_reg <= sync_count_next;
            sync_q_reg     <= {sync_q_reg[1:0], tdd_sync_i};
        end
    end

    assign enable       = enable_reg;
    assign txnrx        = txnrx_reg;
    assign tdd_sync_o   = sync_o_reg;
    assign tdd_sync_t   = sync_t_reg;
    assign sync_busy    = (state_reg != ST_IDLE);
    assign sync_done    = done_reg;
    assign sync_timeout = timeout_reg;
    assign sync_count   = sync_count_reg;

endmodule

// File: tb/tb_ad9361_multi_sync.sv
// Directed plus randomized bench for ad9361_multi_sync; expectations come from
// a transaction-level model of the sync rules (NUM_CHIPS=2, W=4, timeout=16).
module tb_ad9361_multi_sync;

    localparam int NC = 2;
    localparam int W  = 4;
    localparam int TO = 16;

    logic          axi_aclk = 1'b0;
    logic          axi_areset;
    logic          mode_master;
    logic          sync_arm;
    logic [NC-1:0] up_enable;
    logic [NC-1:0] up_txnrx;
    logic [NC-1:0] enable;
    logic [NC-1:0] txnrx;
    logic          tdd_sync_i;
    logic          tdd_sync_o;
    logic          tdd_sync_t;
    logic          sync_busy;
    logic          sync_done;
    logic          sync_timeout;
    logic [15:0]   sync_count;

    int checks   = 0;
    int failures = 0;

    logic [NC-1:0] exp_en;
    logic [NC-1:0] exp_tx;
    logic [15:0]   exp_count;
    logic          exp_timeout;

    ad9361_multi_sync #(
        .NUM_CHIPS(NC),
        .SYNC_PULSE_WIDTH(W),
        .ARM_TIMEOUT(TO)
    ) dut (
        .axi_aclk(axi_aclk),
        .axi_areset(axi_areset),
        .mode_master(mode_master),
        .sync_arm(sync_arm),
        .up_enable(up_enable),
        .up_txnrx(up_txnrx),
        .enable(enable),
        .txnrx(txnrx),
        .tdd_sync_i(tdd_sync_i),
        .tdd_sync_o(tdd_sync_o),
        .tdd_sync_t(tdd_sync_t),
        .sync_busy(sync_busy),
        .sync_done(sync_done),
        .sync_timeout(sync_timeout),
        .sync_count(sync_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic step();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_state(input string tag);
        check({tag, "_busy"}, 32'(sync_busy), 32'd0);
        check({tag, "_en"}, 32'(enable), 32'(exp_en));
        check({tag, "_tx"}, 32'(txnrx), 32'(exp_tx));
        check({tag, "_cnt"}, 32'(sync_count), 32'(exp_count));
        check({tag, "_to"}, 32'(sync_timeout), 32'(exp_timeout));
    endtask

    // Master: event one edge after arm, W-cycle pulse, done one edge after it ends.
    task automatic do_master(input logic [NC-1:0] en, input logic [NC-1:0] tx, input bit arm_during);
        mode_master = 1'b1;
        up_enable   = en;
        up_txnrx    = tx;
        sync_arm    = 1'b1;
        step();
        sync_arm    = 1'b0;
        exp_timeout = 1'b0;
        check("m_arm_busy", 32'(sync_busy), 32'd1);
        check("m_arm_to", 32'(sync_timeout), 32'd0);
        check("m_arm_en", 32'(enable), 32'(exp_en));
        check("m_arm_o", 32'(tdd_sync_o), 32'd0);
        check("m_arm_t", 32'(tdd_sync_t), 32'd0);
        exp_en = en;
        exp_tx = tx;
        for (int i = 1; i <= W; i++) begin
            step();
            check("m_pulse_o", 32'(tdd_sync_o), 32'd1);
            check("m_pulse_en", 32'(enable), 32'(exp_en));
            check("m_pulse_tx", 32'(txnrx), 32'(exp_tx));
            check("m_pulse_busy", 32'(sync_busy), 32'd1);
            check("m_pulse_done", 32'(sync_done), 32'd0);
            if (arm_during) sync_arm = 1'b1;
        end
        step();
        sync_arm  = 1'b0;
        exp_count = exp_count + 16'd1;
        check("m_end_o", 32'(tdd_sync_o), 32'd0);
        check("m_end_done", 32'(sync_done), 32'd1);
        check_idle_state("m_end");
        step();
        check("m_post_done", 32'(sync_done), 32'd0);
        check_idle_state("m_post");
        $display("master en=%b tx=%b arm_during=%0d count=%0h", en, tx, arm_during, sync_count);
    endtask

    // Slave: pin raised d cycles after arm; outputs load two edges after first sample.
    task automatic do_slave(input logic [NC-1:0] en0, input logic [NC-1:0] tx0,
                            input logic [NC-1:0] en, input logic [NC-1:0] tx,
                            input int d, input bit flip);
        mode_master = 1'b0;
        tdd_sync_i  = 1'b0;
        up_enable   = en0;
        up_txnrx    = tx0;
        sync_arm    = 1'b1;
        step();
        sync_arm    = 1'b0;
        exp_timeout = 1'b0;
        check("s_arm_busy", 32'(sync_busy), 32'd1);
        check("s_arm_to", 32'(sync_timeout), 32'd0);
        check("s_arm_t", 32'(tdd_sync_t), 32'd1);
        if (flip) mode_master = 1'b1;
        up_enable = en;
        up_txnrx  = tx;
        for (int i = 0; i < d; i++) begin
            step();
            check("s_wait_busy", 32'(sync_busy), 32'd1);
            check("s_wait_en", 32'(enable), 32'(exp_en));
            check("s_wait_o", 32'(tdd_sync_o), 32'd0);
        end
        tdd_sync_i = 1'b1;
        step();
        check("s_k0_en", 32'(enable), 32'(exp_en));
        step();
        check("s_k1_en", 32'(enable), 32'(exp_en));
        check("s_k1_done", 32'(sync_done), 32'd0);
        check("s_k1_busy", 32'(sync_busy), 32'd1);
        step();
        exp_en    = en;
        exp_tx    = tx;
        exp_count = exp_count + 16'd1;
        check("s_k2_done", 32'(sync_done), 32'd1);
        check("s_k2_o", 32'(tdd_sync_o), 32'd0);
        check_idle_state("s_k2");
        tdd_sync_i  = 1'b0;
        mode_master = 1'b0;
        step();
        check("s_post_done", 32'(sync_done), 32'd0);
        step();
        step();
        check_idle_state("s_post");
        $display("slave en=%b tx=%b delay=%0d flip=%0d count=%0h", en, tx, d, flip, sync_count);
    endtask

    task automatic do_timeout();
        mode_master = 1'b0;
        tdd_sync_i  = 1'b0;
        up_enable   = ~exp_en;
        up_txnrx    = ~exp_tx;
        sync_arm    = 1'b1;
        step();
        sync_arm    = 1'b0;
        exp_timeout = 1'b0;
        check("t_arm_to", 32'(sync_timeout), 32'd0);
        for (int i = 1; i < TO; i++) begin
            step();
            check("t_wait_busy", 32'(sync_busy), 32'd1);
            check("t_wait_to", 32'(sync_timeout), 32'd0);
        end
        step();
        exp_timeout = 1'b1;
        check("t_end_done", 32'(sync_done), 32'd0);
        check_idle_state("t_end");
        step();
        check_idle_state("t_sticky");
        $display("timeout to=%0d count=%0h", sync_timeout, sync_count);
    endtask

    initial begin
        axi_areset  = 1'b1;
        mode_master = 1'b0;
        sync_arm    = 1'b0;
        up_enable   = '0;
        up_txnrx    = '0;
        tdd_sync_i  = 1'b0;
        exp_en      = '0;
        exp_tx      = '0;
        exp_count   = 16'd0;
        exp_timeout = 1'b0;
        repeat (3) step();
        axi_areset = 1'b0;
        repeat (10) step();
        check("rst_o", 32'(tdd_sync_o), 32'd0);
        check("rst_t", 32'(tdd_sync_t), 32'd1);
        check("rst_done", 32'(sync_done), 32'd0);
        check_idle_state("rst");
        $display("reset checked");

        do_master(2'b11, 2'b01, 1'b0);
        do_slave(2'b01, 2'b11, 2'b10, 2'b00, 20 - 7, 1'b0);
        do_timeout();
        do_master(2'b01, 2'b10, 1'b0);

        // Arm during PULSE must not trigger a second sync.
        do_master(2'b10, 2'b11, 1'b1);
        repeat (4) step();
        check_idle_state("rb_arm");

        // Pin activity in IDLE is ignored.
        mode_master = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tdd_sync_i = i[0];
            step();
            check("rb_pin_busy", 32'(sync_busy), 32'd0);
            check("rb_pin_done", 32'(sync_done), 32'd0);
        end
        tdd_sync_i = 1'b0;
        repeat (3) step();
        check_idle_state("rb_pin");
        $display("robustness checked");

        for (int n = 0; n < 10; n++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            if (sel == 0)
                do_master(NC'($urandom), NC'($urandom), 1'($urandom));
            else if (sel == 1)
                do_slave(NC'($urandom), NC'($urandom), NC'($urandom), NC'($urandom),
                         int'($urandom_range(0, TO - 3)), 1'($urandom));
            else
                do_timeout();
        end

        force dut.sync_count_reg = 16'hFFFF;
        step();
        release dut.sync_count_reg;
        step();
        exp_count = 16'hFFFF;
        check("wrap_pre", 32'(sync_count), 32'hFFFF);
        do_master(2'b11, 2'b10, 1'b0);
        check("wrap_post", 32'(sync_count), 32'h0000);

        // Reset in the middle of a pulse.
        mode_master = 1'b1;
        sync_arm    = 1'b1;
        step();
        sync_arm = 1'b0;
        step();
        step();
        check("mid_pulse_o", 32'(tdd_sync_o), 32'd1);
        axi_areset = 1'b1;
        step();
        exp_en      = '0;
        exp_tx      = '0;
        exp_count   = 16'd0;
        exp_timeout = 1'b0;
        check("mr_o", 32'(tdd_sync_o), 32'd0);
        check("mr_done", 32'(sync_done), 32'd0);
        check("mr_t", 32'(tdd_sync_t), 32'd1);
        check_idle_state("mr");
        axi_areset = 1'b0;
        step();
        check("mr_post_done", 32'(sync_done), 32'd0);
        check_idle_state("mr_post");
        $display("mid-pulse reset checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad9361_multi_sync.md
# ad9361_multi_sync

Parametrised multi-chip sync controller for the AD9361 PL subsystem. It applies per-chip ENABLE/TXNRX updates to NUM_CHIPS radios in the same clock cycle, aligned to a TDD sync event. That event is generated locally in master mode or taken from the shared `tdd_sync` pin in slave mode. It replaces the direct `up_enable`/`up_txnrx` pass-through with a timed, count-tracked, timeout-protected handshake, so a single or multi-AD9361 board can switch all chips coherently.

## Interface
Parameters:
- `NUM_CHIPS`, 2: number of AD9361 devices driven (1..8).
- `SYNC_PULSE_WIDTH`, 4: master-mode `tdd_sync_o` high time in cycles (1..255).
- `ARM_TIMEOUT`, 1024: slave-mode cycles to wait for an external edge before aborting (2..65535).

Ports:
- `axi_aclk`  in  1  sole clock.
- `axi_areset`  in  1  reset; synchronous, active-high.
- `mode_master`  in  1  1 = generate sync, 0 = follow `tdd_sync_i`; latched on arm.
- `sync_arm`  in  1  request; accepted only in IDLE.
- `up_enable`  in  NUM_CHIPS  requested ENABLE per chip.
- `up_txnrx`  in  NUM_CHIPS  requested TXNRX per chip.
- `enable`  out  NUM_CHIPS  registered ENABLE to chips.
- `txnrx`  out  NUM_CHIPS  registered TXNRX to chips.
- `tdd_sync_i`  in  1  sync pin input, asynchronous.
- `tdd_sync_o`  out  1  sync pin drive value.
- `tdd_sync_t`  out  1  sync pin tristate (1 = hi-Z).
- `sync_busy`  out  1  high in any state other than IDLE.
- `sync_done`  out  1  one-cycle pulse on completion.
- `sync_timeout`  out  1  sticky slave timeout flag.
- `sync_count`  out  16  completed syncs, wrapping.

## Operation
- States: IDLE, ARMED, PULSE.
- IDLE:
  - `sync_arm`=1 → ARMED.
  - Latch `mode_master` into `mode_q`.
  - Clear `sync_timeout`.
  - Clear the timeout counter.
- ARMED, master: next cycle → PULSE (the event cycle).
- ARMED, slave:
  - Detected rising edge → event cycle, then IDLE.
  - Else the counter increments. When it reaches ARM_TIMEOUT-1: → IDLE, `sync_timeout`=1, no output update, no `sync_done`.
  - Edge and timeout in the same cycle: edge wins.
- Event cycle: `enable`/`txnrx` load `up_enable`/`up_txnrx` for all chips on the same edge. These are the only updates to `enable`/`txnrx`.
- PULSE (master only):
  - `tdd_sync_o`=1 for exactly SYNC_PULSE_WIDTH cycles.
  - Then → IDLE with `sync_done`.
- Completion (master after PULSE, slave on event): `sync_done` pulses 1 cycle and `sync_count` += 1. Wrap is 0xFFFF → 0x0000.
- `tdd_sync_i` synchroniser: two flops, plus a third flop for edge detect. Edge = q2 & ~q3. Edges seen in IDLE, or in master mode, are ignored.
- `sync_arm` asserted while busy is ignored and not queued. Changes to `mode_master` while busy have no effect.
- `tdd_sync_t` is registered: it equals ~`mode_master` one cycle later, in every state. `tdd_sync_o` is 0 outside PULSE.

## Timing
- Reset values: `enable`=0, `txnrx`=0, `tdd_sync_o`=0, `tdd_sync_t`=1, `sync_busy`=0, `sync_done`=0, `sync_timeout`=0, `sync_count`=0, state IDLE, synchroniser flops 0.
- Reset asserted mid-operation: all of the above apply at the next edge, including mid-pulse.
- Master, `sync_arm` sampled at edge a:
  - ARMED at a.
  - At a+1: PULSE, `tdd_sync_o`=1, `enable`/`txnrx` updated.
  - `tdd_sync_o` falls at a+1+W.
  - `sync_done`=1 for the cycle after a+1+W.
  - `sync_busy` high from a to a+1+W.
- Slave, `tdd_sync_i` first sampled high at edge k while ARMED:
  - q2=1 at k+1.
  - Outputs updated and `sync_done` asserted at k+2.
  - IDLE at k+2.
- Timeout: with arm at edge a and no edge, `sync_timeout` rises and IDLE is entered at a+ARM_TIMEOUT.
- Back-to-back operation: a new arm is accepted in the cycle `sync_done` is high, since the state is already IDLE.

## Test plan
- Reset, then idle 10 cycles → all outputs equal reset values, `tdd_sync_t`=1 before `mode_master` is applied.
- Master, NUM_CHIPS=2, W=4, `up_enable`=2'b11, `up_txnrx`=2'b01, arm at edge 10 → at edge 11 `enable`=11, `txnrx`=01, `tdd_sync_o` high edges 11–14, `sync_done` after edge 15, `sync_count`=1.
- Slave: arm, `tdd_sync_i` rises 20 cycles later with `up_enable`=2'b10 → `enable`=10 two edges after first sampling, `sync_done` pulse, `tdd_sync_o` stays 0, `tdd_sync_t`=1.
- Slave, ARM_TIMEOUT=16, no edge → `sync_timeout`=1 at arm+16, `enable` unchanged, `sync_count` unchanged. Next arm clears the flag.
- Robustness: `sync_arm` pulsed during PULSE and `tdd_sync_i` toggled in IDLE → neither causes a second sync. Force `sync_count`=0xFFFF, then one sync → 0x0000.
- Apply `axi_areset` mid-PULSE → next edge `tdd_sync_o`=0, `sync_busy`=0, `enable`=0, no `sync_done`.
